parking_gate_ctrl: RTL and testbench

//   Entry-barrier controller downstream of the 3-slot parking block.

---
 rtl/parking_gate_ctrl.sv | 126 ++++++++++++
 tb/tb_parking_gate_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Entry-barrier controller: admits one waiting car at a time into the lowest free slot,
// opens the barrier until the car passes or the open timer expires, and counts admissions.
module parking_gate_ctrl #(
  parameter int NUM_SLOTS   = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int CNT_W       = 8,
  parameter int SLOT_W      = 2
) (
  input  logic                 i_ckt,
  input  logic                 i_rst,
  input  logic [NUM_SLOTS-1:0] i_slot_occ,
  input  logic                 i_free,
  input  logic                 i_entry_req,
  input  logic                 i_car_passed,
  output logic                 o_gate_open,
  output logic                 o_assign_valid,
  output logic [SLOT_W-1:0]    o_assign_slot,
  output logic                 o_full_lamp,
  output logic                 o_timed_out,
  output logic [CNT_W-1:0]     o_admit_cnt
);

  localparam int TMR_W = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic              r_gate, w_gate_nxt;
  logic              r_valid, w_valid_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic              r_full;
  logic              r_to, w_to_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic              w_space;
  logic [SLOT_W-1:0] w_free_idx;

  // FREE alone is not trusted: an all-occupied map means full regardless.
  assign w_space = i_free & ~(&i_slot_occ);

  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_slot_occ[i]) w_free_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_gate_nxt  = r_gate;
    w_valid_nxt = 1'b0;
    w_slot_nxt  = r_slot;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_gate_nxt = 1'b0;
        if (i_entry_req && w_space) begin
          w_state_nxt = S_OPEN;
          w_gate_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_slot_nxt  = w_free_idx;
          w_timer_nxt = TMR_W'(OPEN_CYCLES - 1);
        end
      end
      S_OPEN: begin
        if (i_car_passed) begin
          w_state_nxt = S_HOLD;
          w_gate_nxt  = 1'b0;
          if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (r_timer == '0) begin
          w_state_nxt = S_HOLD;
          w_gate_nxt  = 1'b0;
          w_to_nxt    = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      S_HOLD: begin
        // Wait for the request to drop so the same car is never admitted twice.
        w_gate_nxt = 1'b0;
        if (!i_entry_req) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_ckt) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_gate  <= 1'b0;
      r_valid <= 1'b0;
      r_slot  <= '0;
      r_full  <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_gate  <= w_gate_nxt;
      r_valid <= w_valid_nxt;
      r_slot  <= w_slot_nxt;
      r_full  <= ~w_space;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_gate_open    = r_gate;
  assign o_assign_valid = r_valid;
  assign o_assign_slot  = r_slot;
  assign o_full_lamp    = r_full;
  assign o_timed_out    = r_to;
  assign o_admit_cnt    = r_cnt;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst, free, req, pass;
  logic [2:0] occ;

  logic       o_gate, o_valid, o_full, o_to;
  logic [1:0] o_slot;
  logic [7:0] o_cnt;
  logic       o2_gate, o2_valid, o2_full, o2_to;
  logic [1:0] o2_slot;
  logic [1:0] o2_cnt;

  always #5 clk = ~clk;

  parking_gate_ctrl #(.NUM_SLOTS(3), .OPEN_CYCLES(8), .CNT_W(8), .SLOT_W(2)) u_dut (
    .i_ckt(clk), .i_rst(rst), .i_slot_occ(occ), .i_free(free),
    .i_entry_req(req), .i_car_passed(pass),
    .o_gate_open(o_gate), .o_assign_valid(o_valid), .o_assign_slot(o_slot),
    .o_full_lamp(o_full), .o_timed_out(o_to), .o_admit_cnt(o_cnt)
  );

  parking_gate_ctrl #(.NUM_SLOTS(3), .OPEN_CYCLES(8), .CNT_W(2), .SLOT_W(2)) u_dut2 (
    .i_ckt(clk), .i_rst(rst), .i_slot_occ(occ), .i_free(free),
    .i_entry_req(req), .i_car_passed(pass),
    .o_gate_open(o2_gate), .o_assign_valid(o2_valid), .o_assign_slot(o2_slot),
    .o_full_lamp(o2_full), .o_timed_out(o2_to), .o_admit_cnt(o2_cnt)
  );

  typedef struct packed {
    logic       gate;
    logic       valid;
    logic       full;
    logic       to;
    logic [1:0] slot;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] e_cnt;
  logic [1:0] e_slot;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic cyc(input logic r, input logic p, input logic e_gate,
                     input logic e_valid, input logic e_to);
    exp_t e;
    req  = r;
    pass = p;
    e.gate  = e_gate;
    e.valid = e_valid;
    e.to    = e_to;
    e.full  = rst ? 1'b0 : !(free && (occ != 3'b111));
    e.slot  = e_slot;
    e.cnt   = e_cnt;
    e.cnt2  = (e_cnt > 8'd3) ? 2'd3 : e_cnt[1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gate_open",    {7'd0, o_gate},  {7'd0, e.gate});
    chk("assign_valid", {7'd0, o_valid}, {7'd0, e.valid});
    chk("assign_slot",  {6'd0, o_slot},  {6'd0, e.slot});
    chk("full_lamp",    {7'd0, o_full},  {7'd0, e.full});
    chk("timed_out",    {7'd0, o_to},    {7'd0, e.to});
    chk("admit_cnt",    o_cnt,           e.cnt);
    chk("gate_open_w2", {7'd0, o2_gate}, {7'd0, e.gate});
    chk("valid_w2",     {7'd0, o2_valid},{7'd0, e.valid});
    chk("slot_w2",      {6'd0, o2_slot}, {6'd0, e.slot});
    chk("full_w2",      {7'd0, o2_full}, {7'd0, e.full});
    chk("timed_out_w2", {7'd0, o2_to},   {7'd0, e.to});
    chk("admit_cnt_w2", {6'd0, o2_cnt},  {6'd0, e.cnt2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b1; free = 1'b1; occ = 3'b000; pass = 1'b0;
    e_cnt = 8'd0; e_slot = 2'd0;
    #2;

    // reset held with a pending request
    repeat (2) cyc(1, 0, 0, 0, 0);

    // admit into slot 1, car passes during 3rd open cycle
    rst = 1'b0; occ = 3'b001;
    e_slot = 2'd1;
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    e_cnt = 8'd1;
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // lot full; stray pass pulse in IDLE ignored
    occ = 3'b111; free = 1'b0;
    for (int i = 0; i < 20; i++) cyc(1, (i == 5), 0, 0, 0);
    free = 1'b1;
    repeat (4) cyc(1, 0, 0, 0, 0);
    occ = 3'b000; free = 1'b0;
    repeat (2) cyc(1, 0, 0, 0, 0);

    // timeout: gate high exactly 8 cycles, then TIMED_OUT pulse
    free = 1'b1; e_slot = 2'd0;
    cyc(1, 0, 1, 1, 0);
    repeat (7) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, (i == 2), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0);

    // pass on the timer-expiry edge wins over timeout
    repeat (7) cyc(1, 0, 1, 0, 0);
    e_cnt = 8'd2;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // three more passes: wide counter reaches 5, narrow one saturates at 3
    repeat (3) begin
      cyc(1, 0, 1, 1, 0);
      e_cnt = e_cnt + 8'd1;
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end

    // reset during the 4th open cycle
    cyc(1, 0, 1, 1, 0);
    repeat (3) cyc(1, 0, 1, 0, 0);
    rst = 1'b1; e_cnt = 8'd0; e_slot = 2'd0;
    cyc(1, 0, 0, 0, 0);

    // normal admission after reset; slot held while occupancy changes
    rst = 1'b0; occ = 3'b011; e_slot = 2'd2;
    cyc(1, 0, 1, 1, 0);
    occ = 3'b111; free = 1'b0;
    cyc(1, 0, 1, 0, 0);
    e_cnt = 8'd1;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
